// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the clocked 32-bit ALU: decodes ALUOp/funct, registers operands,
// waits out the ALU latency and returns the result. Optional macro ALU_SLT_EN enables funct 101010 (slt).
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] imm,
  output logic [3:0]       ALU_control,
  output logic [WIDTH-1:0] arg1,
  output logic [WIDTH-1:0] arg2,
  input  logic [WIDTH-1:0] ALU_result,
  input  logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_t     state;
  logic       is_branch_q;
  logic       dec_legal;
  logic [3:0] dec_ctrl;
  logic [WIDTH-1:0] capture_val;

`ifdef ALU_SLT_EN
  logic dec_slt;
  logic is_slt_q;
  logic ovf;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = OP_AND;
`ifdef ALU_SLT_EN
    dec_slt   = 1'b0;
`endif
    unique case (ALUOp)
      2'b00: begin dec_legal = 1'b1; dec_ctrl = OP_ADD; end
      2'b01: begin dec_legal = 1'b1; dec_ctrl = OP_SUB; end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_legal = 1'b1; dec_ctrl = OP_ADD; end
          6'b100010: begin dec_legal = 1'b1; dec_ctrl = OP_SUB; end
          6'b100100: begin dec_legal = 1'b1; dec_ctrl = OP_AND; end
          6'b100101: begin dec_legal = 1'b1; dec_ctrl = OP_OR;  end
`ifdef ALU_SLT_EN
          6'b101010: begin dec_legal = 1'b1; dec_ctrl = OP_SUB; dec_slt = 1'b1; end
`endif
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_SLT_EN
  // Signed less-than from the subtract result, corrected for signed overflow.
  assign ovf = (arg1[WIDTH-1] != arg2[WIDTH-1]) && (ALU_result[WIDTH-1] != arg1[WIDTH-1]);
  assign capture_val = is_slt_q ? {{(WIDTH-1){1'b0}}, ALU_result[WIDTH-1] ^ ovf} : ALU_result;
`else
  assign capture_val = ALU_result;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ALU_control  <= 4'b0000;
      arg1         <= '0;
      arg2         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      is_branch_q  <= 1'b0;
`ifdef ALU_SLT_EN
      is_slt_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            is_branch_q <= (ALUOp == 2'b01);
`ifdef ALU_SLT_EN
            is_slt_q    <= dec_slt;
`endif
            if (dec_legal) begin
              ALU_control <= dec_ctrl;
              arg1        <= rs_val;
              arg2        <= ALUSrc ? imm : rt_val;
              state       <= S_ISSUE;
            end else begin
              // Illegal requests leave the ALU-facing registers untouched.
              result       <= '0;
              illegal      <= 1'b1;
              branch_taken <= 1'b0;
              done         <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          result       <= capture_val;
          branch_taken <= is_branch_q & Zero;
          illegal      <= 1'b0;
          done         <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural model of the registered ALU.
// Compile with or without +define+ALU_SLT_EN to match the RTL build.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic        ALUSrc;
  logic [31:0] rs_val, rt_val, imm;
  logic [3:0]  ALU_control;
  logic [31:0] arg1, arg2;
  logic [31:0] ALU_result = '0;
  logic        Zero = 1'b0;
  logic        busy, done, branch_taken, illegal;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  // Expected ALU-facing register contents (held across illegal requests).
  logic [3:0]  exp_ctrl = 4'b0000;
  logic [31:0] exp_a1 = '0;
  logic [31:0] exp_a2 = '0;

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .funct(funct), .ALUSrc(ALUSrc),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .ALU_control(ALU_control),
    .arg1(arg1), .arg2(arg2), .ALU_result(ALU_result), .Zero(Zero), .busy(busy),
    .done(done), .result(result), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Registered ALU: one-cycle latency from arguments to result/zero.
  always @(posedge clk) begin
    logic [31:0] r;
    case (ALU_control)
      4'b0010: r = arg1 + arg2;
      4'b0110: r = arg1 - arg2;
      4'b0000: r = arg1 & arg2;
      4'b0001: r = arg1 | arg2;
      default: r = '0;
    endcase
    ALU_result <= r;
    Zero       <= (r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    ALUOp  = 2'($urandom);
    funct  = 6'($urandom);
    ALUSrc = 1'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    imm    = $urandom;
  endtask

  // One request end to end, with expectations derived from the instruction semantics.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic src,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    logic [31:0] bv, exp_res;
    logic [3:0]  ctrl;
    logic        legal, exp_br;
    int          lat;
    bit          seen;
    bv = src ? im : b;
    legal = 1'b1; exp_br = 1'b0; ctrl = 4'b0000; exp_res = '0;
    case (op)
      2'd0: begin ctrl = 4'b0010; exp_res = a + bv; end
      2'd1: begin ctrl = 4'b0110; exp_res = a - bv; exp_br = (a == bv); end
      2'd2: begin
        case (f)
          6'h20: begin ctrl = 4'b0010; exp_res = a + bv; end
          6'h22: begin ctrl = 4'b0110; exp_res = a - bv; end
          6'h24: begin ctrl = 4'b0000; exp_res = a & bv; end
          6'h25: begin ctrl = 4'b0001; exp_res = a | bv; end
`ifdef ALU_SLT_EN
          6'h2A: begin ctrl = 4'b0110; exp_res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0; end
`endif
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin exp_ctrl = ctrl; exp_a1 = a; exp_a2 = bv; end
    else exp_res = '0;

    @(negedge clk);
    ALUOp = op; funct = f; ALUSrc = src; rs_val = a; rt_val = b; imm = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    lat = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), legal ? 32'd2 : 32'd0);
      check("result", result, exp_res);
      check("branch_taken", 32'(branch_taken), 32'(exp_br));
      check("illegal", 32'(illegal), 32'(!legal));
      check("alu_control", 32'(ALU_control), 32'(exp_ctrl));
      check("arg1", arg1, exp_a1);
      check("arg2", arg2, exp_a2);
      check("busy_at_done", 32'(busy), 32'd1);
      // A start pulse during DONE must be ignored.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_single_pulse", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("start_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [5:0] fsel [7];
    bit         done_seen;
    fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
    rst = 1'b1; start = 1'b0;
    ALUOp = '0; funct = '0; ALUSrc = 1'b0; rs_val = '0; rt_val = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ctrl", 32'(ALU_control), 32'd0);
    check("rst_arg1", arg1, 32'd0);
    check("rst_arg2", arg2, 32'd0);
    check("rst_flags", {30'd0, branch_taken, illegal}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(2'd2, 6'h20, 1'b0, 32'd5, 32'd7, 32'd0);
    run_op(2'd1, 6'h00, 1'b0, 32'h1234, 32'h1234, 32'd0);
    run_op(2'd1, 6'h00, 1'b0, 32'h1234, 32'h1235, 32'd0);
    run_op(2'd0, 6'h00, 1'b1, 32'h100, 32'h55, 32'hFFFF_FFFC);
    run_op(2'd2, 6'h27, 1'b0, 32'h1, 32'h2, 32'd0);
    run_op(2'd3, 6'h20, 1'b0, 32'h1, 32'h2, 32'd0);
    run_op(2'd2, 6'h2A, 1'b0, 32'h8000_0000, 32'd1, 32'd0);
    run_op(2'd2, 6'h2A, 1'b0, 32'd1, 32'h8000_0000, 32'd0);

    // Reset while the request sits in WAIT.
    @(negedge clk);
    ALUOp = 2'd0; funct = 6'h20; ALUSrc = 1'b0; rs_val = 32'd9; rt_val = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_ctrl", 32'(ALU_control), 32'd0);
    check("midrst_args", arg1 | arg2, 32'd0);
    exp_ctrl = 4'b0000; exp_a1 = '0; exp_a2 = '0;
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (done) done_seen = 1; end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(2'($urandom), fsel[$urandom_range(0, 6)], 1'($urandom), a, b, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Front-end that drives the clocked 32-bit ALU.
- Decodes the main-control `ALUOp` and the R-type `funct` into the ALU's 4-bit operation code, and selects and registers the operands.
- Waits out the ALU's one-cycle registered latency, then captures `ALU_result` and `Zero`.
- Returns one completed result per request with a done pulse and a branch decision; sits between the datapath/main control and the ALU.

## Interface
Parameters:
- WIDTH, 32, operand/result width (ALU is fixed at 32; other values unsupported)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- ALUOp  in  2  main-control ALU operation class
- funct  in  6  R-type function field
- ALUSrc  in  1  1 = second operand is imm, 0 = rt_val
- rs_val  in  32  first operand
- rt_val  in  32  register second operand
- imm  in  32  sign-extended immediate
- ALU_control  out  4  operation code to ALU
- arg1  out  32  ALU argument 1
- arg2  out  32  ALU argument 2
- ALU_result  in  32  registered ALU result
- Zero  in  1  registered ALU zero flag
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- result  out  32  captured result, held until next completion
- branch_taken  out  1  valid with done
- illegal  out  1  valid with done; unsupported encoding

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when start = 1, decode the request and register ALU_control, arg1 = rs_val, arg2 = (ALUSrc ? imm : rt_val).
  - Legal encoding: go to ISSUE.
  - Illegal encoding: ALU_control/arg1/arg2 are not updated; go directly to DONE with result = 0, illegal = 1, branch_taken = 0.
- Decode table:
  - ALUOp 00 → 0010 (add)
  - ALUOp 01 → 0110 (subtract, branch compare)
  - ALUOp 10, funct 100000 → 0010 (add); 100010 → 0110 (sub); 100100 → 0000 (and); 100101 → 0001 (or)
  - ALUOp 10, any other funct → illegal
  - ALUOp 11 → illegal
- ISSUE: ALU samples the operands at the closing edge; go to WAIT.
- WAIT: ALU outputs are valid. At the closing edge, capture result ← ALU_result and branch_taken ← (ALUOp_q == 01) & Zero; illegal ← 0; go to DONE.
- DONE: done = 1 for exactly this cycle; go to IDLE.
- start is ignored while busy. No queueing; the requester re-asserts start after done.
- ALUOp, funct and ALUSrc are registered at acceptance; later input changes do not affect an in-flight operation.
- ALU_control, arg1 and arg2 hold their last issued values between operations.
- Arithmetic is modulo 2^32; overflow is not flagged (except inside SLT, below).

## Timing
- Request accepted at edge E0 (IDLE, start = 1). ALU latches at E1. Capture at E2. done is high in the cycle following E2.
- Latency: done asserts 3 cycles after the accepting edge; an illegal request completes after 1 cycle.
- Throughput: a new start can be accepted in the cycle after DONE, giving 1 operation per 4 cycles.
- Reset values: state IDLE, ALU_control = 0000, arg1 = 0, arg2 = 0, busy = 0, done = 0, result = 0, branch_taken = 0, illegal = 0.
- Reset mid-operation: immediate return to IDLE; no done pulse; the in-flight ALU result is discarded.
- start asserted on the same edge that rst deasserts: ignored; start is sampled on the first edge with rst = 0.

## Configuration
- ALU_SLT_EN defined:
  - ALUOp 10, funct 101010 (slt) is legal and issues 0110 (subtract).
  - At capture, result = {31'b0, ALU_result[31] ^ ovf}, with ovf = (arg1[31] != arg2[31]) & (ALU_result[31] != arg1[31]).
  - branch_taken = 0 for slt.
- ALU_SLT_EN undefined: funct 101010 is illegal.

## Test plan
- Reset mid-WAIT with rst pulsed → busy = 0 next cycle, no done pulse, all outputs back to reset values.
- ALUOp 10, funct 100000, rs 5, rt 7, ALUSrc 0 → ALU_control 0010, done 3 cycles later, result 12, branch_taken 0.
- ALUOp 01, rs 0x1234, rt 0x1234 → ALU_control 0110, result 0, branch_taken 1; repeat with rt 0x1235 → result 0xFFFFFFFF, branch_taken 0.
- ALUOp 00, ALUSrc 1, rs 0x100, imm 0xFFFFFFFC → arg2 = 0xFFFFFFFC, result 0xFC.
- ALUOp 10, funct 100111 → done 1 cycle after accept, illegal 1, result 0; a second start pulsed while busy is ignored.
- ALU_SLT_EN defined: slt with rs 0x80000000, rt 1 → result 1; rs 1, rt 0x80000000 → result 0. Undefined: same request → illegal 1.
